// File: rtl/conv3x3_engine_if.sv
// Handshake and configuration bundle for the 3x3 convolution engine.
// master: window source / pixel sink side; slave: the engine.
interface conv3x3_engine_if #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned COEF_W  = 8
);
    logic [1:0]           mode;
    logic                 coef_we;
    logic [3:0]           coef_addr;
    logic [COEF_W-1:0]    coef_data;
    logic [9*PIXEL_W-1:0] in_window;
    logic                 in_valid;
    logic                 in_ready;
    logic [PIXEL_W-1:0]   out_pixel;
    logic                 out_clipped;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mode, coef_we, coef_addr, coef_data, in_window, in_valid, out_ready,
        input  in_ready, out_pixel, out_clipped, out_valid
    );

    modport slave (
        input  mode, coef_we, coef_addr, coef_data, in_window, in_valid, out_ready,
        output in_ready, out_pixel, out_clipped, out_valid
    );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: multiply, sum, then round/shift/saturate, as a 3-stage pipeline.
// Kernel is Gaussian, sharpen, runtime-loaded custom, or bypass, selected per window.
module conv3x3_engine #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned COEF_W  = 8,
    parameter int unsigned ACC_W   = PIXEL_W + COEF_W + 4
) (
    input logic             clk,
    input logic             rst_n,
    conv3x3_engine_if.slave bus
);
    localparam int unsigned ProdW = COEF_W + PIXEL_W + 1;
    localparam logic [1:0] ModeGauss  = 2'd0;
    localparam logic [1:0] ModeSharp  = 2'd1;
    localparam logic [1:0] ModeCustom = 2'd2;
    localparam logic signed [ACC_W:0] MaxPix = {{(ACC_W + 1 - PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};

    logic                     ce;
    logic signed [COEF_W-1:0] kc_q [9];
    logic [3:0]               shc_q;
    logic signed [COEF_W-1:0] k_sel [9];
    logic [3:0]               sh_sel;
    logic signed [ProdW-1:0]  pix_ext;
    logic signed [ProdW-1:0]  m_d [9];
    logic signed [ProdW-1:0]  m_q [9];
    logic [1:0]               mode1_q, mode2_q;
    logic [3:0]               sh1_q, sh2_q;
    logic                     v1_q, v2_q;
    logic signed [ACC_W-1:0]  sum_d, sum_q;
    logic signed [ACC_W:0]    rnd, biased, shifted;
    logic [PIXEL_W-1:0]       pix_d, pix_q;
    logic                     clip_d, clip_q;
    logic                     ov_q;

    // Whole pipeline advances together unless the output register is full and blocked.
    assign ce               = !ov_q || bus.out_ready;
    assign bus.in_ready     = ce;
    assign bus.out_pixel    = pix_q;
    assign bus.out_clipped  = clip_q;
    assign bus.out_valid    = ov_q;

    // Kernel and shift selection for the window presented this cycle.
    always_comb begin
        for (int i = 0; i < 9; i++) k_sel[i] = '0;
        sh_sel = 4'd0;
        case (bus.mode)
            ModeGauss: begin
                k_sel[0] = COEF_W'(1); k_sel[1] = COEF_W'(2); k_sel[2] = COEF_W'(1);
                k_sel[3] = COEF_W'(2); k_sel[4] = COEF_W'(4); k_sel[5] = COEF_W'(2);
                k_sel[6] = COEF_W'(1); k_sel[7] = COEF_W'(2); k_sel[8] = COEF_W'(1);
                sh_sel   = 4'd4;
            end
            ModeSharp: begin
                k_sel[1] = '1; k_sel[3] = '1; k_sel[5] = '1; k_sel[7] = '1;
                k_sel[4] = COEF_W'(5);
            end
            ModeCustom: begin
                for (int i = 0; i < 9; i++) k_sel[i] = kc_q[i];
                sh_sel = shc_q;
            end
            // Bypass is an identity kernel with no shift; the result can never clip.
            default: k_sel[4] = COEF_W'(1);
        endcase
    end

    // Signed coefficient times zero-extended pixel.
    always_comb begin
        pix_ext = '0;
        for (int i = 0; i < 9; i++) begin
            pix_ext = ProdW'($signed({1'b0, bus.in_window[i*PIXEL_W +: PIXEL_W]}));
            m_d[i]  = ProdW'(k_sel[i]) * pix_ext;
        end
    end

    // Adder tree for the registered products.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) sum_d = sum_d + ACC_W'(m_q[i]);
    end

    // Round-to-nearest, arithmetic shift, then clamp into the pixel range.
    always_comb begin
        rnd = '0;
        if (sh2_q != 4'd0) rnd = {{ACC_W{1'b0}}, 1'b1} << (sh2_q - 4'd1);
        biased  = {sum_q[ACC_W-1], sum_q} + rnd;
        shifted = biased >>> sh2_q;
        pix_d   = shifted[PIXEL_W-1:0];
        clip_d  = 1'b0;
        if (shifted[ACC_W]) begin
            pix_d  = '0;
            clip_d = 1'b1;
        end else if (shifted > MaxPix) begin
            pix_d  = '1;
            clip_d = 1'b1;
        end
    end

    // Custom kernel registers; writes land on the next edge regardless of pipeline state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) kc_q[i] <= (i == 4) ? COEF_W'(1) : '0;
            shc_q <= 4'd0;
        end else if (bus.coef_we) begin
            for (int i = 0; i < 9; i++) begin
                if (bus.coef_addr == 4'(i)) kc_q[i] <= bus.coef_data;
            end
            if (bus.coef_addr == 4'd9) shc_q <= bus.coef_data[3:0];
        end
    end

    // Pipeline stages: products, sum, normalised output; all hold when ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) m_q[i] <= '0;
            mode1_q <= 2'd0;
            sh1_q   <= 4'd0;
            v1_q    <= 1'b0;
            sum_q   <= '0;
            mode2_q <= 2'd0;
            sh2_q   <= 4'd0;
            v2_q    <= 1'b0;
            pix_q   <= '0;
            clip_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else if (ce) begin
            for (int i = 0; i < 9; i++) m_q[i] <= m_d[i];
            mode1_q <= bus.mode;
            sh1_q   <= sh_sel;
            v1_q    <= bus.in_valid;
            sum_q   <= sum_d;
            mode2_q <= mode1_q;
            sh2_q   <= sh1_q;
            v2_q    <= v1_q;
            ov_q    <= v2_q;
            if (v2_q) begin
                pix_q  <= pix_d;
                clip_q <= clip_d;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine with a reference model and an expected-result queue.
module tb_conv3x3_engine;
    localparam int PW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv3x3_engine_if #(.PIXEL_W(PW), .COEF_W(CW)) bus ();

    conv3x3_engine #(.PIXEL_W(PW), .COEF_W(CW), .ACC_W(PW + CW + 4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         n_out = 0;
    int         cyc = 0;
    int         last_lat = 0;
    int         tb_k [9];
    int         tb_sh;
    logic [8:0] exp_q [$];
    int         acc_q [$];
    logic [8:0] last_out;
    logic [8:0] held;
    bit         stall_prev = 0;
    bit         accepted = 0;

    function automatic logic [8:0] model(input logic [9*PW-1:0] w, input logic [1:0] md);
        int k [9];
        int sh;
        int acc;
        sh = 0;
        for (int i = 0; i < 9; i++) k[i] = 0;
        case (md)
            2'd0: begin k = '{1, 2, 1, 2, 4, 2, 1, 2, 1}; sh = 4; end
            2'd1: k = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
            2'd2: begin k = tb_k; sh = tb_sh; end
            default: return {1'b0, w[4*PW +: PW]};
        endcase
        acc = 0;
        for (int i = 0; i < 9; i++) acc += k[i] * int'(w[i*PW +: PW]);
        if (sh > 0) acc += 1 << (sh - 1);
        acc = acc >>> sh;
        if (acc < 0) return 9'h100;
        if (acc > 255) return 9'h1FF;
        return {1'b0, 8'(acc)};
    endfunction

    function automatic logic [9*PW-1:0] uni(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [9*PW-1:0] center(input logic [7:0] c, input logic [7:0] nb);
        logic [9*PW-1:0] w;
        w = {9{nb}};
        w[4*PW +: PW] = c;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) tb_k[i] = (i == 4) ? 1 : 0;
        tb_sh = 0;
    endtask

    // One clock: sample at the falling edge, then let the rising edge happen.
    task automatic step();
        @(negedge clk);
        cyc++;
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) begin
            exp_q.push_back(model(bus.in_window, bus.mode));
            acc_q.push_back(cyc);
        end
        if (stall_prev) begin
            chk("stall_hold", {bus.out_valid, bus.out_clipped, bus.out_pixel} >> 0 ? 
                {bus.out_clipped, bus.out_pixel} : 9'h0, held);
            n_vec++;
            assert (bus.out_valid === 1'b1) else begin
                n_err++;
                $error("FAIL stall_valid observed=%b expected=1", bus.out_valid);
            end
        end
        if (bus.out_valid && !bus.out_ready) begin
            n_vec++;
            assert (bus.in_ready === 1'b0) else begin
                n_err++;
                $error("FAIL stall_in_ready observed=%b expected=0", bus.in_ready);
            end
            stall_prev = 1;
            held = {bus.out_clipped, bus.out_pixel};
        end else begin
            stall_prev = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_output observed=%h expected=none",
                       {bus.out_clipped, bus.out_pixel});
            end
            if (exp_q.size() != 0) begin
                last_out = {bus.out_clipped, bus.out_pixel};
                chk("scoreboard", last_out, exp_q.pop_front());
                last_lat = cyc - acc_q.pop_front();
            end
        end
        @(posedge clk);
        if (bus.coef_we) begin
            if (bus.coef_addr < 4'd9) tb_k[bus.coef_addr] = int'($signed(bus.coef_data));
            else if (bus.coef_addr == 4'd9) tb_sh = int'(bus.coef_data[3:0]);
        end
        #1;
    endtask

    task automatic drain(input bit use_pat);
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        while (exp_q.size() != 0 && n < 60) begin
            bus.out_ready = use_pat ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
            step();
            n++;
        end
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
        end
        bus.out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] rnd;
        logic [71:0] wi;
        int n0, sent, guard;
        bit first;

        rst_n = 1'b0;
        bus.mode = 2'd0; bus.coef_we = 1'b0; bus.coef_addr = 4'd0; bus.coef_data = '0;
        bus.in_window = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        model_reset();
        #1;
        chk("reset_out_valid", {8'd0, bus.out_valid}, 9'd0);
        chk("reset_out_pixel", {1'b0, bus.out_pixel}, 9'd0);
        chk("reset_out_clipped", {8'd0, bus.out_clipped}, 9'd0);
        chk("reset_in_ready", {8'd0, bus.in_ready}, 9'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Gaussian: uniform 200, and latency with no stall.
        bus.mode = 2'd0; bus.in_window = uni(8'd200); bus.in_valid = 1'b1;
        step();
        drain(0);
        chk("gauss_uniform", last_out, {1'b0, 8'd200});
        chk("gauss_latency", 9'(last_lat), 9'd3);
        bus.in_window = center(8'd255, 8'd0); bus.in_valid = 1'b1;
        step();
        drain(0);
        chk("gauss_center255", last_out, {1'b0, 8'd64});

        // Sharpen: high clip, low clip, uniform.
        bus.mode = 2'd1; bus.in_window = center(8'd250, 8'd0); bus.in_valid = 1'b1;
        step();
        bus.in_window = center(8'd0, 8'd100);
        step();
        drain(0);
        chk("sharpen_low_clip", last_out, {1'b1, 8'd0});
        bus.in_window = uni(8'd77); bus.in_valid = 1'b1;
        step();
        drain(0);
        chk("sharpen_uniform", last_out, {1'b0, 8'd77});

        // Custom: window in the same cycle as a k write sees the identity kernel.
        bus.mode = 2'd2; bus.in_window = uni(8'd9); bus.in_valid = 1'b1;
        bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 8'd1;
        step();
        drain(0);
        chk("custom_old_kernel", last_out, {1'b0, 8'd9});
        bus.coef_we = 1'b1; bus.coef_data = 8'd1;
        for (int a = 1; a < 9; a++) begin
            bus.coef_addr = 4'(a);
            step();
        end
        bus.coef_addr = 4'd9; bus.coef_data = 8'hF3;
        step();
        bus.coef_addr = 4'd12; bus.coef_data = 8'h55;
        step();
        bus.coef_we = 1'b0; bus.in_window = uni(8'd9); bus.in_valid = 1'b1;
        step();
        drain(0);
        chk("custom_ones_shift3", last_out, {1'b0, 8'd10});

        // Backpressure: 10 windows back-to-back, out_ready pattern 1,0,0,1.
        n0 = n_out; sent = 0; guard = 0; first = 1;
        while (sent < 10 && guard < 100) begin
            if (first || accepted) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                bus.in_window = rnd[71:0];
                bus.mode = 2'(sent % 4);
                first = 0;
            end
            bus.in_valid = 1'b1;
            bus.out_ready = (guard % 4 == 0) || (guard % 4 == 3);
            step();
            if (accepted) sent++;
            guard++;
        end
        drain(1);
        chk("bp_output_count", 9'(n_out - n0), 9'd10);

        // Mode interleave on one window.
        wi = 72'h10_F0_33_C8_7E_05_A1_64_2D;
        n0 = n_out;
        bus.in_window = wi; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.mode = 2'd0; step();
        bus.mode = 2'd1; step();
        bus.mode = 2'd3; step();
        bus.mode = 2'd2; step();
        drain(0);
        chk("interleave_count", 9'(n_out - n0), 9'd4);

        // Reset with windows in flight.
        bus.mode = 2'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_window = uni(8'd11); step();
        bus.in_window = uni(8'd22); step();
        bus.in_window = uni(8'd33); step();
        bus.in_valid = 1'b0;
        chk("pre_reset_valid", {8'd0, bus.out_valid}, 9'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_midstream_valid", {8'd0, bus.out_valid}, 9'd0);
        exp_q.delete();
        acc_q.delete();
        stall_prev = 0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n0 = n_out;
        repeat (5) step();
        chk("post_reset_silent", 9'(n_out - n0), 9'd0);
        bus.mode = 2'd2; bus.in_window = center(8'd123, 8'd45); bus.in_valid = 1'b1;
        step();
        drain(0);
        chk("post_reset_identity", last_out, {1'b0, 8'd123});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
Parametrised 3x3 convolution engine, the next generation of the fixed Gaussian blur stage in the image pipeline. Takes one packed 3x3 window per accepted transfer and applies a selectable kernel: Gaussian, sharpen, runtime-loadable custom, or bypass. Output is rounded, normalised and saturated. Full valid/ready backpressure on both sides, fixed 3-stage pipeline. Sits between the line-buffer/window generator and the downstream pixel sink.

Parameters:
PIXEL_W, 8, unsigned pixel width, input and output
COEF_W, 8, signed two's-complement coefficient width for the custom kernel
ACC_W, PIXEL_W+COEF_W+4, signed accumulator width; must be at least PIXEL_W+COEF_W+4

Ports:
clk  in  1  system clock, all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  2  kernel select, sampled with each accepted window: 0 Gaussian, 1 sharpen, 2 custom, 3 bypass
coef_we  in  1  custom-kernel register write strobe
coef_addr  in  4  0..8 selects coefficient k[0..8]; 9 selects shift; 10..15 ignored
coef_data  in  COEF_W  write data; for addr 9 only bits [3:0] are used
in_window  in  9*PIXEL_W  window; p[i] = in_window[i*PIXEL_W +: PIXEL_W], i=0 top-left, row-major
in_valid  in  1  window valid
in_ready  out  1  engine can accept a window this cycle
out_pixel  out  PIXEL_W  convolved pixel
out_clipped  out  1  result saturated, at either 0 or max
out_valid  out  1  out_pixel valid
out_ready  in  1  downstream accepts

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_pixel=0, out_valid=0, out_clipped=0, all stage valids=0. Custom kernel resets to identity: k[4]=1, all other k=0, shift=0.
- Pipeline advance: ce = !out_valid | out_ready. in_ready = ce (combinational). Transfer in when in_valid & in_ready. All three stages hold when ce=0. No bubble is inserted when ce=1.
- Stage 1, multiply: products m[i] = signed(k[i]) * zero-extended p[i]. The kernel and shift are those active in that cycle. The mode and shift are registered alongside the products.
- Stage 2, sum: all 9 products are added into a sum of ACC_W bits, signed.
- Stage 3, normalise: if shift>0, add 2^(shift-1), then arithmetic right shift by shift. Clamp to [0, 2^PIXEL_W-1]. out_clipped=1 if the clamp changed the value.
- Latency: 3 cycles from an accepted input to out_valid, with no stall. Throughput is 1 pixel/cycle.
- Fixed kernels:
  - Gaussian: 1 2 1 / 2 4 2 / 1 2 1, shift 4, round-to-nearest.
  - Sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0, shift 0.
  - Bypass: result = p[4], out_clipped=0.
- Mode is per-window. A mode change between transfers affects only later windows and never requires a flush.
- Coefficient writes: take effect on the next clock edge. A window multiplied in the same cycle as a write uses the old value. Writes are accepted regardless of in_valid or stall state. A write to addr 10..15 has no effect. Addr 9 sets shift = coef_data[3:0], range 0..15.
- out_pixel and out_clipped hold stable while out_valid=1 and out_ready=0.
- An rst_n assert mid-stream discards all in-flight pixels and restores the custom kernel to identity.

Test Plan:
- Gaussian, all p=200, mode 0 -> out_pixel=200 after 3 cycles, out_clipped=0. With p[4]=255 and others 0 -> 1020+8>>4 = 64.
- Sharpen, p[4]=250, neighbours 0 -> 1250 clamps to 255, out_clipped=1. p[4]=0, neighbours 100 -> -400 clamps to 0, out_clipped=1. Uniform 77 -> 77.
- Custom: write k[0..8]=1, shift=3 via addr 9, all p=9 -> (81+4)>>3 = 10. A window accepted in the same cycle as the k write still uses the old kernel.
- Backpressure: stream 10 windows back-to-back while out_ready is toggled with pattern 1,0,0,1 -> exactly 10 outputs, in order, with no duplicates. in_ready=0 on each stalled cycle. Data is stable during stalls.
- Mode interleave: 0,1,3,2 on consecutive cycles with the same window -> 4 outputs, each matching its own mode.
- Reset mid-stream: assert rst_n=0 with 2 windows in flight -> out_valid=0 immediately, no outputs emitted after release, and a custom-mode window afterwards returns p[4].
